// File: rtl/operand_fetch.sv
// operand_fetch: issues regfile reads, forwards write-back data, presents rs1/rs2 operands; OPF_PERF_CNT_EN adds stall/bypass counters.
module operand_fetch #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             rf_rd_en,
  output logic [AW-1:0]    rf_rs1_addr,
  output logic [AW-1:0]    rf_rs2_addr,
  input  logic [XLEN-1:0]  rf_rs1_data,
  input  logic [XLEN-1:0]  rf_rs2_data,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_rs1_val,
  output logic [XLEN-1:0]  out_rs2_val,
  output logic [TAG_W-1:0] out_tag
`ifdef OPF_PERF_CNT_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_byp_cnt
`endif
);
  logic             s1_valid, s1_ovr1, s1_ovr2;
  logic [AW-1:0]    s1_rs1, s1_rs2, out_rs1, out_rs2;
  logic [TAG_W-1:0] s1_tag;
  logic [XLEN-1:0]  s1_od1, s1_od2, op1, op2;
  logic             out_adv, s1_adv, acc;
  logic             hit_in1, hit_in2, hit_s1, hit_s2, hit_o1, hit_o2;
  assign out_adv     = out_valid & out_ready;
  assign s1_adv      = s1_valid & (~out_valid | out_adv);
  assign in_ready    = ~s1_valid | s1_adv;
  assign acc         = in_valid & in_ready;
  assign rf_rd_en    = acc;
  assign rf_rs1_addr = in_rs1;
  assign rf_rs2_addr = in_rs2;
  // x0 never matches, so write-backs to it are never forwarded
  assign hit_in1 = wb_en && wb_addr == in_rs1  && in_rs1  != '0;
  assign hit_in2 = wb_en && wb_addr == in_rs2  && in_rs2  != '0;
  assign hit_s1  = wb_en && wb_addr == s1_rs1  && s1_rs1  != '0;
  assign hit_s2  = wb_en && wb_addr == s1_rs2  && s1_rs2  != '0;
  assign hit_o1  = wb_en && wb_addr == out_rs1 && out_rs1 != '0;
  assign hit_o2  = wb_en && wb_addr == out_rs2 && out_rs2 != '0;
  always_comb begin
    op1 = s1_rs1 == '0 ? '0 : hit_s1 ? wb_data : s1_ovr1 ? s1_od1 : rf_rs1_data;
    op2 = s1_rs2 == '0 ? '0 : hit_s2 ? wb_data : s1_ovr2 ? s1_od2 : rf_rs2_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_rs1   <= '0;
      s1_rs2   <= '0;
      s1_tag   <= '0;
      s1_ovr1  <= 1'b0;
      s1_ovr2  <= 1'b0;
      s1_od1   <= '0;
      s1_od2   <= '0;
    end else if (acc) begin
      s1_valid <= 1'b1;
      s1_rs1   <= in_rs1;
      s1_rs2   <= in_rs2;
      s1_tag   <= in_tag;
      s1_ovr1  <= hit_in1;
      s1_ovr2  <= hit_in2;
      s1_od1   <= wb_data;
      s1_od2   <= wb_data;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end else if (s1_valid) begin
      if (hit_s1) begin
        s1_ovr1 <= 1'b1;
        s1_od1  <= wb_data;
      end
      if (hit_s2) begin
        s1_ovr2 <= 1'b1;
        s1_od2  <= wb_data;
      end
    end
  end
  // indices travel with the result so a stalled output can still pick up write-backs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_tag     <= '0;
    end else if (s1_adv) begin
      out_valid   <= 1'b1;
      out_rs1     <= s1_rs1;
      out_rs2     <= s1_rs2;
      out_rs1_val <= op1;
      out_rs2_val <= op2;
      out_tag     <= s1_tag;
    end else if (out_adv) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      if (hit_o1) out_rs1_val <= wb_data;
      if (hit_o2) out_rs2_val <= wb_data;
    end
  end
`ifdef OPF_PERF_CNT_EN
  logic byp;
  assign byp = hit_s1 | s1_ovr1 | hit_s2 | s1_ovr2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_byp_cnt   <= '0;
    end else begin
      if (in_valid & ~in_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (s1_adv & byp) perf_byp_cnt <= perf_byp_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed scoreboard bench for operand_fetch with a synchronous-read regfile model.
module tb_operand_fetch;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [4:0]  in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_tag = '0;
  logic        rf_rd_en;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data = '0, rf_rs2_data = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_rs1_val, out_rs2_val, out_tag;
`ifdef OPF_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_byp_cnt;
`endif
  typedef struct packed {logic [31:0] r1, r2, tag;} exp_t;
  exp_t        q[$];
  logic [31:0] rf_m [32];
  int          n_vec = 0, n_bad = 0;
  operand_fetch dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag), .rf_rd_en(rf_rd_en),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_tag(out_tag)
`ifdef OPF_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_byp_cnt(perf_byp_cnt)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rf_rd_en) begin
      rf_rs1_data <= rf_m[rf_rs1_addr];
      rf_rs2_data <= rf_m[rf_rs2_addr];
    end
    if (wb_en && wb_addr != 5'd0) rf_m[wb_addr] <= wb_data;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", out_tag, 32'hDEAD_BEEF);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("rs1_val", out_rs1_val, e.r1);
        chk("rs2_val", out_rs2_val, e.r2);
        chk("tag", out_tag, e.tag);
      end
    end
  end
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic req(input logic [4:0] a, input logic [4:0] b, input logic [31:0] t);
    in_valid = 1'b1;
    in_rs1 = a;
    in_rs2 = b;
    in_tag = t;
  endtask
  task automatic wb(input logic e, input logic [4:0] a, input logic [31:0] d);
    wb_en = e;
    wb_addr = a;
    wb_data = d;
  endtask
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] t);
    q.push_back('{a, b, t});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_rs1", out_rs1_val, 32'd0);
    chk("rst_rs2", out_rs2_val, 32'd0);
    chk("rst_tag", out_tag, 32'd0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    wb(1, 5, 32'h11); cyc();
    wb(1, 6, 32'h06); cyc();
    wb(1, 7, 32'h77); cyc();
    wb(0, 0, 0); cyc();
    // basic read and 2-cycle latency
    req(5, 0, 32'hA); push(32'h11, 32'h0, 32'hA); cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_t1_valid", {31'd0, out_valid}, 32'd0);
    cyc();
    @(negedge clk);
    chk("lat_t2_valid", {31'd0, out_valid}, 32'd1);
    cyc(3);
    // write-back during accept
    req(5, 6, 32'hB); wb(1, 5, 32'h22); push(32'h22, 32'h06, 32'hB); cyc();
    in_valid = 1'b0; wb(0, 0, 0); cyc(3);
    // write-back the cycle after accept, rs1==rs2
    req(5, 5, 32'hC); push(32'h33, 32'h33, 32'hC); cyc();
    in_valid = 1'b0; wb(1, 5, 32'h33); cyc();
    wb(0, 0, 0); cyc(3);
    // backpressure with write-back into held S1 and OUT
    out_ready = 1'b0;
    req(6, 7, 32'h10); push(32'h44, 32'h77, 32'h10); cyc();
    req(7, 6, 32'h11); push(32'h77, 32'h44, 32'h11);
    chk("bp_ready_r2", {31'd0, in_ready}, 32'd1);
    cyc();
    req(6, 6, 32'h12); push(32'h44, 32'h44, 32'h12); wb(1, 6, 32'h44);
    chk("bp_full_0", {31'd0, in_ready}, 32'd0);
    cyc();
    wb(0, 0, 0);
    chk("bp_full_1", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("bp_full_2", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0; cyc(4);
    chk("bp_drained", q.size(), 32'd0);
    // x0 is never forwarded
    req(0, 5, 32'h20); wb(1, 0, 32'hFF); push(32'h0, 32'h33, 32'h20); cyc();
    in_valid = 1'b0; wb(0, 0, 0); cyc(3);
    // reset while stalled drops in-flight work
    out_ready = 1'b0;
    req(5, 6, 32'h30); cyc();
    req(6, 5, 32'h31); cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_tag", out_tag, 32'd0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    cyc(3);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    // 3 stall cycles and 2 forwarded transfers
    out_ready = 1'b0;
    req(7, 7, 32'h40); wb(1, 7, 32'h71); push(32'h72, 32'h72, 32'h40); cyc();
    req(7, 7, 32'h41); wb(1, 7, 32'h72); push(32'h72, 32'h72, 32'h41); cyc();
    wb(0, 0, 0);
    req(7, 7, 32'h42); push(32'h72, 32'h72, 32'h42);
    cyc(3);
    out_ready = 1'b1; cyc();
    in_valid = 1'b0; cyc(5);
`ifdef OPF_PERF_CNT_EN
    chk("perf_stall", perf_stall_cnt, 32'd3);
    chk("perf_byp", perf_byp_cnt, 32'd2);
`endif
    chk("final_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
